// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU op decode and operand select with a skid-buffered valid/ready EX register
// Main register feeds the ALU directly; one skid entry absorbs the op accepted while EX is stalled.
module alu_issue_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ILLCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          alu_op,
    input  logic [5:0]          funct,
    input  logic                alu_src,
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [DATA_W-1:0]   rt_data,
    input  logic [DATA_W-1:0]   imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   operand_A,
    output logic [DATA_W-1:0]   operand_B,
    output logic [3:0]          operation,
    output logic                illegal,
    output logic [ILLCNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        op;
        logic              ill;
    } entry_t;

    entry_t                main_q, main_d;
    entry_t                skid_q, skid_d;
    logic                  main_v_q, main_v_d;
    logic                  skid_v_q, skid_v_d;
    logic [ILLCNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;

    entry_t                new_entry;
    logic [3:0]            dec_op;
    logic                  dec_ill;
    logic                  acc;
    logic                  cons;

    always_comb begin
        dec_op  = 4'b0000;
        dec_ill = 1'b0;
        case (alu_op)
            2'b00: dec_op = 4'b0010;
            2'b01: dec_op = 4'b0110;
            2'b11: dec_op = 4'b0111;
            default: begin
                case (funct)
                    6'b100000: dec_op = 4'b0010;
                    6'b100010: dec_op = 4'b0110;
                    6'b100100: dec_op = 4'b0000;
                    6'b100101: dec_op = 4'b0001;
                    6'b100111: dec_op = 4'b1100;
                    6'b101010: dec_op = 4'b0111;
                    default:   dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        new_entry.a   = rs_data;
        new_entry.b   = alu_src ? imm : rt_data;
        new_entry.op  = dec_op;
        new_entry.ill = dec_ill;
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
    assign in_ready = ~skid_v_q;
    assign acc      = in_valid & in_ready;
    assign cons     = main_v_q & out_ready;

    always_comb begin
        main_d        = main_q;
        main_v_d      = main_v_q;
        skid_d        = skid_q;
        skid_v_d      = skid_v_q;
        illegal_cnt_d = illegal_cnt_q;

        if (!main_v_q || cons) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (acc) begin
                main_d   = new_entry;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (acc) begin
            skid_d   = new_entry;
            skid_v_d = 1'b1;
        end

        if (acc && dec_ill && (illegal_cnt_q != {ILLCNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + ILLCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q        <= '0;
            main_v_q      <= 1'b0;
            skid_q        <= '0;
            skid_v_q      <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            main_q        <= main_d;
            main_v_q      <= main_v_d;
            skid_q        <= skid_d;
            skid_v_q      <= skid_v_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = main_v_q;
    assign operand_A   = main_q.a;
    assign operand_B   = main_q.b;
    assign operation   = main_q.op;
    assign illegal     = main_q.ill;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam int DATA_W   = 32;
    localparam int ILLCNT_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          alu_op;
    logic [5:0]          funct;
    logic                alu_src;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   operand_A;
    logic [DATA_W-1:0]   operand_B;
    logic [3:0]          operation;
    logic                illegal;
    logic [ILLCNT_W-1:0] illegal_cnt;

    alu_issue_ctrl #(.DATA_W(DATA_W), .ILLCNT_W(ILLCNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .alu_src(alu_src),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_A(operand_A), .operand_B(operand_B), .operation(operation),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        op;
        logic              ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    int   cycles   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] aop, input logic [5:0] f,
                                       output logic [3:0] op, output logic ill);
        ill = 1'b0;
        op  = 4'b0000;
        if (aop == 2'b00)      op = 4'b0010;
        else if (aop == 2'b01) op = 4'b0110;
        else if (aop == 2'b11) op = 4'b0111;
        else if (f == 6'h20)   op = 4'b0010;
        else if (f == 6'h22)   op = 4'b0110;
        else if (f == 6'h24)   op = 4'b0000;
        else if (f == 6'h25)   op = 4'b0001;
        else if (f == 6'h27)   op = 4'b1100;
        else if (f == 6'h2A)   op = 4'b0111;
        else                   ill = 1'b1;
    endfunction

    always @(posedge clk) cycles++;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            pops++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("out_A", operand_A, e.a);
                check("out_B", operand_B, e.b);
                check("out_op", operation, e.op);
                check("out_ill", illegal, e.ill);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the op
    task automatic send(input logic [1:0] aop, input logic [5:0] f, input logic src,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im);
        exp_t e;
        bit   done = 0;
        alu_op = aop; funct = f; alu_src = src;
        rs_data = rs; rt_data = rt; imm = im;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.a = rs;
                e.b = src ? im : rt;
                ref_decode(aop, f, e.op, e.ill);
                sb_q.push_back(e);
                if (e.ill && exp_cnt < 255) exp_cnt++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_A"}, operand_A, 0);
        check({tag, "_B"}, operand_B, 0);
        check({tag, "_op"}, operation, 0);
        check({tag, "_ill"}, illegal, 0);
        check({tag, "_cnt"}, illegal_cnt, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int c0;
        int p0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct = '0; alu_src = 1'b0;
        rs_data = '0; rt_data = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // sub via funct, one-cycle latency
        out_ready = 1'b1;
        send(2'b10, 6'b100010, 1'b0, 32'd7, 32'd3, 32'd99);
        check("lat_valid", out_valid, 1);
        check("lat_op", operation, 4'b0110);
        check("lat_A", operand_A, 32'd7);
        check("lat_B", operand_B, 32'd3);

        // add with immediate operand
        send(2'b00, 6'b000000, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFC);
        check("imm_B", operand_B, 32'hFFFF_FFFC);
        check("imm_ill", illegal, 0);
        @(posedge clk); #1;

        // stall: X into main, Y into skid, then drain
        out_ready = 1'b0;
        send(2'b10, 6'b100100, 1'b0, 32'hA, 32'hB, 32'h0);
        check("stall_x_ready", in_ready, 1);
        send(2'b10, 6'b100101, 1'b0, 32'hC, 32'hD, 32'h0);
        check("stall_y_ready", in_ready, 0);
        repeat (2) @(posedge clk); #1;
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_A", operand_A, 32'hA);
        p0 = pops;
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("drain_pops", pops - p0, 2);
        check("drain_empty", out_valid, 0);
        check("drain_ready", in_ready, 1);

        // 16 back-to-back mixed ops
        c0 = cycles;
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            logic [5:0] fn_tab [6];
            fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
            send(2'(i % 4), fn_tab[i % 6], 1'(i % 2), $urandom, $urandom, $urandom);
        end
        check("b2b_cycles", cycles - c0, 16);
        @(posedge clk); #1;
        check("b2b_pops", pops - p0, 16);

        // illegal funct saturation
        for (int i = 0; i < 300; i++) begin
            send(2'b10, 6'b000000, 1'b0, i, ~i, 32'h0);
        end
        repeat (2) @(posedge clk); #1;
        check("cnt_model", illegal_cnt, exp_cnt);
        check("cnt_sat", illegal_cnt, 255);
        check("sb_drained", sb_q.size(), 0);

        // async reset with both entries occupied
        out_ready = 1'b0;
        send(2'b01, 6'b0, 1'b0, 32'h11, 32'h22, 32'h0);
        send(2'b11, 6'b0, 1'b0, 32'h33, 32'h44, 32'h0);
        check("pre_rst_full", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        reset_checks("async_rst");
        sb_q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(2'b10, 6'b101010, 1'b0, 32'h5, 32'h6, 32'h0);
        check("post_rst_op", operation, 4'b0111);
        @(posedge clk); #1;
        check("post_rst_sb", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
